// File: rtl/mips_pkg.sv
// Constants and state type shared by the fetch stage and the pc register.
package mips_pkg;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory and decode handshakes seen from the fetch stage (master).
interface fetch_stage_if;
  import mips_pkg::*;

  logic              o_imem_req;
  logic [ADDR_W-1:0] o_imem_addr;
  logic              i_imem_gnt;
  logic              i_imem_rvalid;
  logic [DATA_W-1:0] i_imem_rdata;
  logic              o_valid;
  logic [DATA_W-1:0] o_instr;
  logic [ADDR_W-1:0] o_instr_pc;
  logic              i_ready;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    output o_valid, o_instr, o_instr_pc,
    input  i_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    input  o_valid, o_instr, o_instr_pc,
    output i_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch control around the pc register: single-outstanding imem request,
// registered instruction output to decode, redirect with in-flight kill.
module fetch_stage #(
  parameter int unsigned              ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned              DATA_W   = mips_pkg::DATA_W,
  parameter logic [mips_pkg::ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [ADDR_W-1:0] o_next_pc,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  fetch_stage_if.master     bus
);
  import mips_pkg::fetch_state_t;
  import mips_pkg::S_REQ;
  import mips_pkg::S_WAIT;
  import mips_pkg::S_OUT;

  fetch_state_t      state_q, state_d;
  logic              valid_q, valid_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              imem_req;
  logic [ADDR_W-1:0] next_pc;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    req_pc_d   = req_pc_q;
    imem_req   = 1'b0;
    next_pc    = i_pc;

    case (state_q)
      S_REQ: begin
        imem_req = !i_redirect;
        if (imem_req && bus.i_imem_gnt) begin
          req_pc_d = i_pc;
          next_pc  = i_pc + 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response is dropped if it was killed earlier or a redirect coincides with it.
        if (bus.i_imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || i_redirect) begin
            state_d = S_REQ;
          end else begin
            instr_d    = bus.i_imem_rdata;
            instr_pc_d = req_pc_q;
            valid_d    = 1'b1;
            state_d    = S_OUT;
          end
        end else if (i_redirect) begin
          kill_d = 1'b1;
        end
      end
      S_OUT: begin
        if (i_redirect || bus.i_ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (i_redirect) next_pc = i_redirect_pc;
    if (!i_rst_n) begin
      imem_req = 1'b0;
      next_pc  = RESET_PC;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_REQ;
      valid_q    <= 1'b0;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign o_next_pc       = next_pc;
  assign bus.o_imem_req  = imem_req;
  assign bus.o_imem_addr = i_pc;
  assign bus.o_valid     = valid_q;
  assign bus.o_instr     = instr_q;
  assign bus.o_instr_pc  = instr_pc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level fetch model, pc register and
// random-latency instruction memory, directed scenarios then random traffic.
module tb_fetch_stage;
  import mips_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  fetch_stage_if bus ();

  fetch_stage #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pc          (pc_q),
    .o_next_pc     (next_pc),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  // Stand-in for the external pc register.
  always_ff @(posedge clk) pc_q <= next_pc;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [ADDR_W-1:0] a);
    if (a == '0) return 32'h2408_0005;
    return {a, 2'b00} ^ 32'hC3A5_5A3C;
  endfunction

  // Reference model: architectural fetch PC, one outstanding memory access,
  // and the instruction currently offered to decode.
  logic [ADDR_W-1:0] m_pc       = RESET_PC;
  bit                m_pending  = 0;
  bit                m_killed   = 0;
  logic [ADDR_W-1:0] m_req_addr = '0;
  int unsigned       m_lat      = 0;
  bit                m_held     = 0;
  logic [DATA_W-1:0] m_instr    = '0;
  logic [ADDR_W-1:0] m_ipc      = '0;

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc(input bit rst, input bit redir, input logic [ADDR_W-1:0] tgt,
                     input bit rdy, input bit gnt_en, input int unsigned lat, input bit spur_rv);
    bit                rv;
    bit                exp_req;
    bit                gnt;
    logic [ADDR_W-1:0] exp_next;

    check_eq("valid", 32'(bus.o_valid), 32'(m_held));
    check_eq("instr", bus.o_instr, m_instr);
    check_eq("instr_pc", 32'(bus.o_instr_pc), 32'(m_ipc));
    if (!rst) check_eq("pc_reg", 32'(pc_q), 32'(m_pc));

    rst_n       = !rst;
    redirect    = redir;
    redirect_pc = tgt;
    bus.i_ready = rdy;
    rv = 0;
    if (m_pending && !rst) begin
      if (m_lat > 0) m_lat--;
      rv = (m_lat == 0);
    end
    if (spur_rv) rv = 1;
    bus.i_imem_rvalid = rv;
    bus.i_imem_rdata  = (rv && m_pending) ? memf(m_req_addr) : 32'($urandom);
    bus.i_imem_gnt    = 1'b0;

    #1;
    exp_req = !rst && !m_held && !m_pending && !redir;
    check_eq("imem_req", 32'(bus.o_imem_req), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", 32'(bus.o_imem_addr), 32'(m_pc));
    gnt = exp_req && gnt_en;
    bus.i_imem_gnt = gnt;
    #1;
    if (rst)        exp_next = RESET_PC;
    else if (redir) exp_next = tgt;
    else if (gnt)   exp_next = m_pc + 1'b1;
    else            exp_next = m_pc;
    check_eq("next_pc", 32'(next_pc), 32'(exp_next));

    @(posedge clk);
    if (rst) begin
      m_held = 0; m_pending = 0; m_killed = 0; m_instr = '0; m_ipc = '0;
    end else begin
      if (m_held && (rdy || redir)) m_held = 0;
      if (m_pending && rv) begin
        m_pending = 0;
        if (!m_killed && !redir) begin
          m_held  = 1;
          m_instr = memf(m_req_addr);
          m_ipc   = m_req_addr;
        end
        m_killed = 0;
      end else if (m_pending && redir) begin
        m_killed = 1;
      end
      if (gnt) begin
        m_pending  = 1;
        m_killed   = 0;
        m_req_addr = m_pc;
        m_lat      = lat;
      end
    end
    m_pc = exp_next;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, '0, rdy, 0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0; bus.i_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset then first fetch from 0, decode stalled four cycles.
    cyc(1, 0, '0, 0, 1, 1, 0);
    cyc(0, 0, '0, 0, 1, 1, 0);
    idle(0);
    check_eq("first_instr", bus.o_instr, 32'h2408_0005);
    check_eq("first_ipc", 32'(bus.o_instr_pc), 32'd0);
    repeat (4) idle(0);
    cyc(0, 0, '0, 1, 0, 1, 0);
    check_eq("next_addr", 32'(bus.o_imem_addr), 32'd1);

    // Redirect while waiting; the late response must be dropped.
    cyc(0, 0, '0, 0, 1, 3, 0);
    cyc(0, 1, 30'd122, 0, 0, 1, 0);
    idle(0);
    idle(0);
    check_eq("killed_valid", 32'(bus.o_valid), 32'd0);
    check_eq("redir_addr", 32'(bus.o_imem_addr), 32'd122);

    // Redirect coincident with rvalid.
    cyc(0, 0, '0, 0, 1, 2, 0);
    idle(0);
    cyc(0, 1, 30'd40, 0, 0, 1, 0);
    idle(0);

    // PC wrap-around.
    cyc(0, 1, 30'h3FFF_FFFF, 0, 0, 1, 0);
    cyc(0, 0, '0, 0, 1, 1, 0);
    idle(0);
    check_eq("wrap_ipc", 32'(bus.o_instr_pc), 32'h3FFF_FFFF);
    check_eq("wrap_pc", 32'(pc_q), 32'd0);
    idle(1);

    // Reset in the middle of a wait, then a stray late rvalid.
    cyc(0, 0, '0, 0, 1, 3, 0);
    idle(0);
    cyc(1, 0, '0, 0, 0, 1, 0);
    check_eq("rst_instr", bus.o_instr, 32'd0);
    cyc(0, 0, '0, 0, 0, 1, 1);
    idle(0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit                r_rst, r_redir, r_rdy, r_gnt, r_spur;
      logic [ADDR_W-1:0] r_tgt;
      r_rst   = ($urandom % 150) == 0;
      r_redir = ($urandom % 8) == 0;
      r_tgt   = ($urandom % 4 == 0) ? (30'h3FFF_FFFE + 30'($urandom % 2)) : 30'($urandom);
      r_rdy   = ($urandom % 3) != 0;
      r_gnt   = ($urandom % 2) != 0;
      r_spur  = m_held && !r_rst && (($urandom % 4) == 0);
      cyc(r_rst, r_redir, r_tgt, r_rdy, r_gnt, $urandom_range(1, 4), r_spur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch control stage wrapped around the existing `pc` register.
- Consumes the current word PC (`pc.o_pc`) and computes the next PC (drives `pc.i_pc`).
- Issues single-outstanding requests to instruction memory and presents fetched instructions to decode through a valid/ready handshake.
- Handles branch/jump redirects, including discarding a response that is already in flight.

Parameters:
- ADDR_W, 30, word-address width; matches `pc` width.
- DATA_W, 32, instruction width.
- RESET_PC, 30'h0000_0000, word address driven on `o_next_pc` during reset.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset, sampled on rising `i_clk`.
- i_pc  in  ADDR_W  current PC, from `pc.o_pc`.
- o_next_pc  out  ADDR_W  next PC, to `pc.i_pc`; combinational.
- o_imem_req  out  1  memory request valid.
- o_imem_addr  out  ADDR_W  request word address.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  read data valid.
- i_imem_rdata  in  DATA_W  instruction word.
- o_valid  out  1  instruction available to decode.
- o_instr  out  DATA_W  instruction, registered.
- o_instr_pc  out  ADDR_W  word PC of `o_instr`, registered.
- i_ready  in  1  decode accepts instruction.
- i_redirect  in  1  branch/jump taken; highest priority.
- i_redirect_pc  in  ADDR_W  redirect target, word address.

Behaviour:
- State register values: S_REQ, S_WAIT, S_OUT. Internal registers: `req_pc[ADDR_W]` and `kill`.
- Reset (`i_rst_n`=0 at a clock edge):
  - state goes to S_REQ.
  - `o_valid`, `kill` are cleared.
  - `o_instr`, `o_instr_pc` and `req_pc` are cleared to 0.
  - While `i_rst_n`=0, combinationally: `o_imem_req`=0 and `o_next_pc`=RESET_PC.
- Default next-PC: `o_next_pc` = `i_pc`, i.e. the PC holds.
- S_REQ:
  - `o_imem_req` = !`i_redirect`; `o_imem_addr` = `i_pc`.
  - On `i_imem_gnt` (request asserted): `req_pc` <= `i_pc`; `o_next_pc` = `i_pc`+1; go to S_WAIT.
  - Otherwise stay.
- S_WAIT:
  - `o_imem_req`=0.
  - On `i_imem_rvalid` with `kill`=1: drop the data, `kill` <= 0, go to S_REQ.
  - On `i_imem_rvalid` with `kill`=0: `o_instr` <= `i_imem_rdata`; `o_instr_pc` <= `req_pc`; `o_valid` <= 1; go to S_OUT.
  - Latency: data is visible on `o_instr` the cycle after `rvalid`.
- S_OUT:
  - `o_valid`=1 and the outputs hold stable while `i_ready`=0.
  - On `i_ready`=1: `o_valid` <= 0, go to S_REQ.
  - No new request is issued in S_OUT.
- Redirect (`i_redirect`=1, any state) overrides all of the above:
  - `o_next_pc` = `i_redirect_pc` this cycle; `o_imem_req` is gated to 0 this cycle.
  - In S_REQ: stay in S_REQ.
  - In S_WAIT without `rvalid`: `kill` <= 1, stay in S_WAIT.
  - In S_WAIT with `rvalid` the same cycle: drop the data, go to S_REQ, `kill` <= 0.
  - In S_OUT: `o_valid` <= 0, go to S_REQ; the instruction is discarded even if `i_ready`=1.
- PC arithmetic: ADDR_W-bit unsigned with wrap-around; 30'h3FFF_FFFF+1 = 30'h0. No byte offset bits exist.
- Ordering and spurious input:
  - At most one outstanding request.
  - `rvalid` outside S_WAIT is ignored.
  - A grant and `rvalid` in the same cycle cannot occur; there is a minimum 1-cycle memory latency.
- Reset mid-operation: any in-flight response is abandoned. Memory must also be reset by the same `i_rst_n`; a late `rvalid` lands in S_REQ and is ignored.

Decomposition:
- Shared package `mips_pkg`:
  - `ADDR_W` and `DATA_W` constants.
  - `RESET_PC` constant, shared with `pc`.
  - `fetch_state_t` enum (S_REQ, S_WAIT, S_OUT).
- No sub-module: the FSM and output register are a single block; `pc` remains a separate instance in the parent.

Test Plan:
- Reset then release, `i_pc`=0, memory with 0-wait grant and 1-cycle `rvalid` returning 32'h2408_0005 -> `o_imem_addr`=0; `o_next_pc`=1 on the grant cycle; `o_valid`=1 with `o_instr`=32'h2408_0005 and `o_instr_pc`=0; the next request goes to addr 1.
- Decode stall: `i_ready`=0 for 4 cycles in S_OUT -> `o_valid`, `o_instr` and `o_instr_pc` stable; `o_imem_req`=0; `o_next_pc` = `i_pc`; on release exactly one instruction is consumed.
- Redirect in S_WAIT to 30'd122 with `rvalid` 2 cycles later -> the response is dropped and `o_valid` never rises; the next `o_imem_addr`=122.
- Redirect coincident with `rvalid` -> data dropped, state S_REQ, `o_next_pc`=`i_redirect_pc` that cycle.
- Wrap: `i_pc`=30'h3FFF_FFFF granted -> `o_next_pc`=0; `o_instr_pc`=30'h3FFF_FFFF.
- Reset asserted in S_WAIT (e.g. at t=345 ns for 40 ns, 50 ns clock) -> next edge: `o_valid`=0, `o_instr`=0, `o_instr_pc`=0, state S_REQ; a late `rvalid` is ignored; `o_next_pc`=RESET_PC while reset is low.
